// File: rtl/demux1_4_deser_if.sv
// Bus bundle for the 1:4 serial demultiplexing deserializer.
//   s        channel select for the current serial bit
//   i        serial data bit
//   i_valid  i and s are valid this cycle
//   i_ready  deserializer accepts the bit this cycle
//   y        four W-bit words, channel k at y[k*W +: W]
//   y_valid  per-channel word complete and held
//   y_ready  per-channel consumer takes the word this cycle
// master: the serial source and word consumers; slave: the deserializer.
interface demux1_4_deser_if #(
    parameter int W = 8
);
    logic [1:0]     s;
    logic           i;
    logic           i_valid;
    logic           i_ready;
    logic [4*W-1:0] y;
    logic [3:0]     y_valid;
    logic [3:0]     y_ready;

    modport master (
        output s, i, i_valid, y_ready,
        input  i_ready, y, y_valid
    );

    modport slave (
        input  s, i, i_valid, y_ready,
        output i_ready, y, y_valid
    );
endinterface

// File: rtl/demux1_4_deser.sv
// Four-channel serial demultiplexing deserializer. Each accepted serial bit
// is shifted into the channel picked by {s[0], s[1]}; after W bits the
// channel presents its word (first bit as MSB) and holds it until drained.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  demux1_4_deser_if.slave (serial input side and word output side)
//
// Per-channel state table:
//   state | meaning
//   FILL  | assembling a word; bits accepted, cnt counts bits so far
//   FULL  | word held on y with y_valid set; waits for y_ready
module demux1_4_deser #(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    demux1_4_deser_if.slave       bus
);
    localparam int CW = $clog2(W) + 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t        state_q [4];
    state_t        state_d [4];
    logic [CW-1:0] cnt_q   [4];
    logic [CW-1:0] cnt_d   [4];
    logic [W-1:0]  sh_q    [4];
    logic [W-1:0]  sh_d    [4];
    logic [W-1:0]  y_q     [4];
    logic [W-1:0]  y_d     [4];

    logic [1:0] sel;
    logic       ready;
    logic       accept;

    // Select encoding is bit-reversed relative to the channel index.
    assign sel    = {bus.s[0], bus.s[1]};
    // A full channel being drained this cycle may take the first bit of its next word.
    assign ready  = (state_q[sel] == FILL) | bus.y_ready[sel];
    assign accept = bus.i_valid & ready;

    assign bus.i_ready = ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= FILL;
                cnt_q[k]   <= '0;
                sh_q[k]    <= '0;
                y_q[k]     <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
                sh_q[k]    <= sh_d[k];
                y_q[k]     <= y_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            sh_d[k]    = sh_q[k];
            y_d[k]     = y_q[k];
        end

        for (int k = 0; k < 4; k++) begin
            if (state_q[k] == FULL && bus.y_ready[k]) begin
                state_d[k] = FILL;
            end
        end

        // An accepted bit can only complete a word from FILL, so it never
        // collides with the drain transition above on the same channel.
        if (accept) begin
            sh_d[sel] = {sh_q[sel][W-2:0], bus.i};
            if (cnt_q[sel] == CW'(W - 1)) begin
                y_d[sel]     = {sh_q[sel][W-2:0], bus.i};
                cnt_d[sel]   = '0;
                state_d[sel] = FULL;
            end else begin
                cnt_d[sel] = cnt_q[sel] + CW'(1);
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_out
        assign bus.y[k*W +: W] = y_q[k];
        assign bus.y_valid[k]  = (state_q[k] == FULL);
    end
endmodule

// File: tb/tb_demux1_4_deser.sv
module tb_demux1_4_deser;
    localparam int W = 8;

    logic clk;
    logic rst;

    demux1_4_deser_if #(.W(W)) bus ();

    demux1_4_deser #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: per channel a queue of received bits, a held word and a full flag.
    bit           m_bits [4][$];
    logic [W-1:0] m_word [4];
    bit           m_full [4];
    bit           started = 0;

    function automatic int ch_of(input logic [1:0] s);
        return (s[0] ? 2 : 0) + (s[1] ? 1 : 0);
    endfunction

    function automatic bit model_ready(input int ch);
        return !m_full[ch] || bus.y_ready[ch];
    endfunction

    always @(posedge clk) begin
        int c;
        bit acc;
        logic [W-1:0] w;
        started = 1;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_bits[k].delete();
                m_word[k] = '0;
                m_full[k] = 0;
            end
        end else begin
            c   = ch_of(bus.s);
            acc = bus.i_valid && model_ready(c);
            for (int k = 0; k < 4; k++)
                if (m_full[k] && bus.y_ready[k]) m_full[k] = 0;
            if (acc) begin
                m_bits[c].push_back(bus.i);
                if (m_bits[c].size() == W) begin
                    w = '0;
                    for (int j = 0; j < W; j++) w = w * 2 + W'(m_bits[c][j]);
                    m_word[c] = w;
                    m_full[c] = 1;
                    m_bits[c].delete();
                end
            end
        end
    end

    // Compare process: every cycle on the falling edge.
    always @(negedge clk) begin
        logic [4*W-1:0] ey;
        logic [3:0]     ev;
        logic           er;
        if (started) begin
            for (int k = 0; k < 4; k++) begin
                ey[k*W +: W] = m_word[k];
                ev[k]        = m_full[k];
            end
            er = model_ready(ch_of(bus.s));
            checks++;
            if (bus.y !== ey) begin
                errors++;
                $display("FAIL y actual=%h expected=%h t=%0t", bus.y, ey, $time);
            end
            checks++;
            if (bus.y_valid !== ev) begin
                errors++;
                $display("FAIL y_valid actual=%b expected=%b t=%0t", bus.y_valid, ev, $time);
            end
            checks++;
            if (bus.i_ready !== er) begin
                errors++;
                $display("FAIL i_ready actual=%b expected=%b t=%0t", bus.i_ready, er, $time);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input int ch, input bit b);
        int  budget;
        bit  done;
        bit  exp;
        budget    = 50;
        done      = 0;
        bus.s     = {ch[0], ch[1]};
        bus.i     = b;
        bus.i_valid = 1'b1;
        while (!done && budget > 0) begin
            exp = model_ready(ch);
            tick();
            if (exp) done = 1;
            budget--;
        end
        if (!done) begin
            errors++;
            $display("FAIL send_bit_timeout actual=stalled expected=accepted ch=%0d", ch);
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic send_word(input int ch, input logic [W-1:0] w);
        for (int j = W - 1; j >= 0; j--) send_bit(ch, w[j]);
    endtask

    task automatic drain_all();
        bus.y_ready = 4'b1111;
        tick();
        bus.y_ready = 4'b0000;
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        bus.s       = 2'b00;
        bus.i       = 1'b0;
        bus.i_valid = 1'b0;
        bus.y_ready = 4'b0000;
        rst         = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_lit("reset_y_valid", 32'(bus.y_valid), 32'h0);
        check_lit("reset_y", bus.y, 32'h0);
        for (int s = 0; s < 4; s++) begin
            bus.s = 2'(s);
            #1;
            check_lit("reset_i_ready", 32'(bus.i_ready), 32'h1);
        end

        // Basic word on ch0: 1,0,1,1,0,0,1,0 -> 8'hB2
        send_word(0, 8'hB2);
        check_lit("ch0_valid", 32'(bus.y_valid), 32'h1);
        check_lit("ch0_word", 32'(bus.y[7:0]), 32'hB2);
        check_lit("model_ch0_word", 32'(m_word[0]), 32'hB2);
        drain_all();
        check_lit("ch0_drained", 32'(bus.y_valid), 32'h0);

        // Channel mapping
        send_word(1, 8'hA5);
        check_lit("ch1_word", 32'(bus.y[15:8]), 32'hA5);
        check_lit("ch1_valid", 32'(bus.y_valid), 32'h2);
        send_word(2, 8'hA5);
        check_lit("ch2_word", 32'(bus.y[23:16]), 32'hA5);
        send_word(3, 8'hA5);
        check_lit("ch3_word", 32'(bus.y[31:24]), 32'hA5);
        check_lit("map_valid", 32'(bus.y_valid), 32'hE);
        drain_all();

        // Interleave ch0 and ch3
        a = 8'h5C;
        b = 8'hE1;
        for (int j = W - 1; j >= 0; j--) begin
            send_bit(0, a[j]);
            if (j == 0) begin
                check_lit("ilv_15th_valid", 32'(bus.y_valid), 32'h1);
            end
            send_bit(3, b[j]);
        end
        check_lit("ilv_valid", 32'(bus.y_valid), 32'h9);
        check_lit("ilv_ch0", 32'(bus.y[7:0]), 32'h5C);
        check_lit("ilv_ch3", 32'(bus.y[31:24]), 32'hE1);
        drain_all();

        // Backpressure on ch0, ch3 keeps flowing
        send_word(0, 8'h3C);
        send_word(3, 8'h69);
        check_lit("bp_ch3_word", 32'(bus.y[31:24]), 32'h69);
        check_lit("bp_valid", 32'(bus.y_valid), 32'h9);
        bus.s       = 2'b00;
        bus.i       = 1'b1;
        bus.i_valid = 1'b1;
        #1;
        check_lit("bp_stall_ready", 32'(bus.i_ready), 32'h0);
        tick();
        tick();
        check_lit("bp_word_stable", 32'(bus.y[7:0]), 32'h3C);
        bus.y_ready = 4'b1001;
        #1;
        check_lit("bp_drain_ready", 32'(bus.i_ready), 32'h1);
        tick();
        bus.y_ready = 4'b0000;
        bus.i_valid = 1'b0;
        check_lit("bp_after_drain", 32'(bus.y_valid), 32'h0);
        for (int j = 0; j < W - 1; j++) send_bit(0, 1'(j & 1));
        check_lit("bp_next_word", 32'(bus.y[7:0]), 32'hAA);
        drain_all();

        // Reset mid-operation
        for (int j = 0; j < 5; j++) send_bit(2, 1'b1);
        send_word(1, 8'h77);
        check_lit("pre_rst_valid", 32'(bus.y_valid), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_lit("rst_valid", 32'(bus.y_valid), 32'h0);
        check_lit("rst_y", bus.y, 32'h0);
        send_word(2, 8'h96);
        check_lit("post_rst_ch2", 32'(bus.y[23:16]), 32'h96);
        check_lit("post_rst_valid", 32'(bus.y_valid), 32'h4);
        drain_all();

        // Randomized traffic checked by the compare process against the model
        for (int n = 0; n < 3000; n++) begin
            bus.s       = 2'($urandom_range(0, 3));
            bus.i       = 1'($urandom_range(0, 1));
            bus.i_valid = ($urandom_range(0, 3) != 0);
            bus.y_ready = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            rst         = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        bus.y_ready = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
